regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: execute (ALU results) and memory (load data).
- Each requester gets a small FIFO. Queue heads are granted round-robin, and same-register writes are kept in program order.
- Drives the regfile write port from registers and flags PC writes so fetch holds off its own PC update.
- Exposes per-register pending-write hazard bits for the decoder's stall logic.

---
 rtl/regfile_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between the execute and memory writeback queues.
// Same-register writes leave in push order; otherwise the queue heads alternate.
module regfile_write_arbiter #(
    parameter int BIT_WIDTH    = 32,
    parameter int REG_COUNT_L2 = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int PC_INDEX     = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [REG_COUNT_L2-1:0] ex_addr,
    input  logic [BIT_WIDTH-1:0]    ex_value,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_COUNT_L2-1:0] mem_addr,
    input  logic [BIT_WIDTH-1:0]    mem_value,
    output logic                    write_enable1,
    output logic [REG_COUNT_L2-1:0] write_addr1,
    output logic [BIT_WIDTH-1:0]    write_value1,
    output logic                    pc_write,
    input  logic [REG_COUNT_L2-1:0] hazard_addr1,
    input  logic [REG_COUNT_L2-1:0] hazard_addr2,
    output logic                    hazard1,
    output logic                    hazard2
);
    localparam int AGE_W = $clog2(2 * FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [REG_COUNT_L2-1:0] PC_ADDR = REG_COUNT_L2'(PC_INDEX);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // Side 0 is execute, side 1 is memory.
    logic [REG_COUNT_L2-1:0] q_addr  [2][FIFO_DEPTH];
    logic [BIT_WIDTH-1:0]    q_value [2][FIFO_DEPTH];
    logic [AGE_W-1:0]        q_age   [2][FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr  [2];
    logic [PTR_W-1:0]        wr_ptr  [2];
    logic [CNT_W-1:0]        count   [2];
    logic [AGE_W-1:0]        age;
    logic                    rr_mem;
    logic                    ready_en;

    logic [1:0]              in_valid;
    logic [REG_COUNT_L2-1:0] in_addr    [2];
    logic [BIT_WIDTH-1:0]    in_value   [2];
    logic [1:0]              ready;
    logic [1:0]              push;
    logic [1:0]              head_valid;
    logic [1:0]              grant;
    logic                    contended;
    logic [REG_COUNT_L2-1:0] head_addr  [2];
    logic [BIT_WIDTH-1:0]    head_value [2];
    logic signed [AGE_W-1:0] age_diff;
    logic [PTR_W-1:0]        hz_idx;

    assign in_valid    = {mem_valid, ex_valid};
    assign in_addr[0]  = ex_addr;
    assign in_addr[1]  = mem_addr;
    assign in_value[0] = ex_value;
    assign in_value[1] = mem_value;
    assign ex_ready    = ready[0];
    assign mem_ready   = ready[1];

    always_comb begin
        ready      = '0;
        push       = '0;
        head_valid = '0;
        for (int s = 0; s < 2; s++) begin
            ready[s]      = ready_en && (count[s] < DEPTH_CNT);
            push[s]       = in_valid[s] && ready[s];
            head_valid[s] = (count[s] != '0);
            head_addr[s]  = q_addr[s][rd_ptr[s]];
            head_value[s] = q_value[s][rd_ptr[s]];
        end
    end

    // Wraparound age difference: negative means the execute head was pushed first.
    assign age_diff = q_age[0][rd_ptr[0]] - q_age[1][rd_ptr[1]];

    always_comb begin
        grant     = head_valid;
        contended = 1'b0;
        if (head_valid == 2'b11) begin
            contended = 1'b1;
            if (head_addr[0] == head_addr[1])
                grant = (age_diff < 0) ? 2'b01 : 2'b10;
            else
                grant = rr_mem ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            age           <= '0;
            rr_mem        <= 1'b0;
            ready_en      <= 1'b0;
            write_enable1 <= 1'b0;
            write_addr1   <= '0;
            write_value1  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (|push)
                age <= age + 1'b1;
            if (contended)
                rr_mem <= grant[0];
            for (int s = 0; s < 2; s++) begin
                if (push[s])
                    wr_ptr[s] <= wr_ptr[s] + 1'b1;
                if (grant[s])
                    rd_ptr[s] <= rd_ptr[s] + 1'b1;
                count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(grant[s]);
            end
            write_enable1 <= |grant;
            if (grant[0]) begin
                write_addr1  <= head_addr[0];
                write_value1 <= head_value[0];
            end else if (grant[1]) begin
                write_addr1  <= head_addr[1];
                write_value1 <= head_value[1];
            end
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                q_addr[s][wr_ptr[s]]  <= in_addr[s];
                q_value[s][wr_ptr[s]] <= in_value[s];
                q_age[s][wr_ptr[s]]   <= age;
            end
        end
    end

    assign pc_write = write_enable1 && (write_addr1 == PC_ADDR);

    always_comb begin
        hazard1 = write_enable1 && (write_addr1 == hazard_addr1);
        hazard2 = write_enable1 && (write_addr1 == hazard_addr2);
        hz_idx  = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (CNT_W'(k) < count[s]) begin
                    hz_idx = rd_ptr[s] + PTR_W'(k);
                    if (q_addr[s][hz_idx] == hazard_addr1) hazard1 = 1'b1;
                    if (q_addr[s][hz_idx] == hazard_addr2) hazard2 = 1'b1;
                end
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        (count[0] <= DEPTH_CNT) && (count[1] <= DEPTH_CNT));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push[0] && count[0] == DEPTH_CNT) && !(push[1] && count[1] == DEPTH_CNT));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, latency, arbitration order,
// backpressure, PC flagging, hazards and asynchronous reset.
module tb_regfile_write_arbiter;
    logic        clk;
    logic        reset;
    logic        ex_valid, ex_ready, mem_valid, mem_ready;
    logic [3:0]  ex_addr, mem_addr;
    logic [31:0] ex_value, mem_value;
    logic        write_enable1, pc_write;
    logic [3:0]  write_addr1;
    logic [31:0] write_value1;
    logic [3:0]  hazard_addr1, hazard_addr2;
    logic        hazard1, hazard2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  ex_a  [8];
    logic [31:0] ex_v  [8];
    logic [3:0]  mem_a [8];
    logic [31:0] mem_v [8];
    logic [3:0]  obs_a [16];
    logic [31:0] obs_v [16];
    int          n_obs;
    logic        saw_full;

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_value(ex_value),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_value(mem_value),
        .write_enable1(write_enable1), .write_addr1(write_addr1), .write_value1(write_value1),
        .pc_write(pc_write),
        .hazard_addr1(hazard_addr1), .hazard_addr2(hazard_addr2),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer ex_a/ex_v and mem_a/mem_v whenever the side is ready; log every write.
    task automatic run_traffic(input int n_ex, input int n_mem, input bit chk_ready);
        int   ei = 0;
        int   mi = 0;
        logic acc_ex, acc_mem, prev_ex_ready, is_ex;
        n_obs = 0;
        saw_full = 1'b0;
        prev_ex_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && n_obs < n_ex + n_mem; cyc++) begin
            if (write_enable1) begin
                obs_a[n_obs] = write_addr1;
                obs_v[n_obs] = write_value1;
                n_obs++;
                is_ex = 1'b0;
                for (int j = 0; j < n_ex; j++)
                    if (ex_a[j] == write_addr1) is_ex = 1'b1;
                if (chk_ready && is_ex && !prev_ex_ready)
                    check_eq("ready_after_pop", ex_ready, 1);
            end
            ex_valid  = (ei < n_ex);
            ex_addr   = ex_a[ei % 8];
            ex_value  = ex_v[ei % 8];
            mem_valid = (mi < n_mem);
            mem_addr  = mem_a[mi % 8];
            mem_value = mem_v[mi % 8];
            if (ex_valid && !ex_ready) saw_full = 1'b1;
            acc_ex  = ex_valid && ex_ready;
            acc_mem = mem_valid && mem_ready;
            prev_ex_ready = ex_ready;
            @(posedge clk);
            if (acc_ex) ei++;
            if (acc_mem) mi++;
            @(negedge clk);
        end
        ex_valid  = 1'b0;
        mem_valid = 1'b0;
        check_eq("traffic_count", n_obs, n_ex + n_mem);
    endtask

    initial begin
        int xi, mi2;
        logic [3:0] rr_exp [6];
        reset = 1'b1;
        ex_valid = 0; ex_addr = 0; ex_value = 0;
        mem_valid = 0; mem_addr = 0; mem_value = 0;
        hazard_addr1 = 0; hazard_addr2 = 0;

        // Reset
        @(posedge clk); @(posedge clk); @(negedge clk);
        check_eq("rst_we", write_enable1, 0);
        check_eq("rst_ex_ready", ex_ready, 0);
        check_eq("rst_mem_ready", mem_ready, 0);
        check_eq("rst_pc_write", pc_write, 0);
        check_eq("rst_addr", write_addr1, 0);
        reset = 1'b0;
        step();
        check_eq("rel_ex_ready", ex_ready, 1);
        check_eq("rel_mem_ready", mem_ready, 1);

        // Single write and hazard window
        ex_valid = 1; ex_addr = 3; ex_value = 32'hDEADBEEF;
        hazard_addr1 = 3; hazard_addr2 = 4;
        step();
        ex_valid = 0;
        check_eq("sw_we_e0", write_enable1, 0);
        check_eq("sw_haz1_e0", hazard1, 1);
        check_eq("sw_haz2_e0", hazard2, 0);
        step();
        check_eq("sw_we_e1", write_enable1, 1);
        check_eq("sw_addr_e1", write_addr1, 3);
        check_eq("sw_value_e1", write_value1, 32'hDEADBEEF);
        check_eq("sw_pc_e1", pc_write, 0);
        check_eq("sw_haz1_e1", hazard1, 1);
        step();
        check_eq("sw_we_e2", write_enable1, 0);
        check_eq("sw_haz1_e2", hazard1, 0);

        // Round-robin on distinct registers, ex first after reset
        ex_a[0] = 1; ex_a[1] = 2; ex_a[2] = 3;
        mem_a[0] = 4; mem_a[1] = 5; mem_a[2] = 6;
        for (int i = 0; i < 3; i++) begin
            ex_v[i]  = 32'h100 + i;
            mem_v[i] = 32'h200 + i;
        end
        rr_exp[0] = 1; rr_exp[1] = 4; rr_exp[2] = 2;
        rr_exp[3] = 5; rr_exp[4] = 3; rr_exp[5] = 6;
        run_traffic(3, 3, 1'b0);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("rr_addr%0d", i), obs_a[i], rr_exp[i]);
        check_eq("rr_value0", obs_v[0], 32'h100);
        check_eq("rr_value1", obs_v[1], 32'h200);

        // Same register, execute head older, pointer now favouring mem
        ex_valid = 1; ex_addr = 9; ex_value = 32'h3;
        mem_valid = 1; mem_addr = 6; mem_value = 32'h60;
        step();
        ex_valid = 0;
        mem_addr = 9; mem_value = 32'h4;
        step();
        mem_valid = 0;
        check_eq("old_addr_e1", write_addr1, 6);
        check_eq("old_value_e1", write_value1, 32'h60);
        step();
        check_eq("old_value_e2", write_value1, 32'h3);
        step();
        check_eq("old_value_e3", write_value1, 32'h4);
        check_eq("old_we_e3", write_enable1, 1);
        step();
        check_eq("old_idle", write_enable1, 0);

        // Program order on r7 across cycles
        mem_valid = 1; mem_addr = 7; mem_value = 32'h1;
        step();
        mem_valid = 0;
        ex_valid = 1; ex_addr = 7; ex_value = 32'h2;
        step();
        ex_valid = 0;
        check_eq("ord_value_first", write_value1, 32'h1);
        step();
        check_eq("ord_value_second", write_value1, 32'h2);
        check_eq("ord_addr_second", write_addr1, 7);
        step();

        // Same-cycle push to r7 twice: mem wins regardless of pointer
        for (int r = 0; r < 2; r++) begin
            ex_valid = 1; ex_addr = 7; ex_value = 32'hA0 + r;
            mem_valid = 1; mem_addr = 7; mem_value = 32'hB0 + r;
            step();
            ex_valid = 0; mem_valid = 0;
            step();
            check_eq($sformatf("same_first%0d", r), write_value1, 32'hB0 + r);
            step();
            check_eq($sformatf("same_second%0d", r), write_value1, 32'hA0 + r);
            step();
        end

        // Backpressure: both sides hold valid, ex fills up
        for (int i = 0; i < 4; i++) begin
            ex_a[i]  = 4'(10 + i); ex_v[i]  = 32'hE0 + i;
            mem_a[i] = 4'(1 + i);  mem_v[i] = 32'hF0 + i;
        end
        run_traffic(4, 4, 1'b1);
        check_eq("bp_saw_full", saw_full, 1);
        xi = 0; mi2 = 0;
        for (int i = 0; i < n_obs; i++) begin
            if (obs_a[i] >= 10) begin
                check_eq($sformatf("bp_ex%0d", xi), obs_v[i], 32'hE0 + xi);
                xi++;
            end else begin
                check_eq($sformatf("bp_mem%0d", mi2), obs_v[i], 32'hF0 + mi2);
                mi2++;
            end
        end
        check_eq("bp_ex_total", xi, 4);
        step();

        // PC write flag
        ex_valid = 1; ex_addr = 15; ex_value = 32'h100;
        step();
        ex_valid = 0;
        check_eq("pc_before", pc_write, 0);
        step();
        check_eq("pc_we", write_enable1, 1);
        check_eq("pc_addr", write_addr1, 15);
        check_eq("pc_flag", pc_write, 1);
        step();
        check_eq("pc_after", pc_write, 0);

        // Asynchronous reset with three entries queued
        ex_valid = 1; ex_addr = 1; ex_value = 32'h11;
        mem_valid = 1; mem_addr = 2; mem_value = 32'h22;
        step();
        ex_addr = 3; ex_value = 32'h33;
        mem_addr = 4; mem_value = 32'h44;
        step();
        ex_valid = 0; mem_valid = 0;
        hazard_addr1 = 3;
        check_eq("ar_we_before", write_enable1, 1);
        check_eq("ar_haz_before", hazard1, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("ar_we_async", write_enable1, 0);
        check_eq("ar_ready_async", ex_ready, 0);
        check_eq("ar_haz_async", hazard1, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("ar_idle%0d", i), write_enable1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
